// File: rtl/alu_issue_ctrl.sv
// Issue sequencer around the pipelined ALU: command FIFO, latency tracking,
// credit-guarded response FIFO. Optional tag path: define ALU_ISSUE_TAG_EN.
module alu_issue_ctrl #(
    parameter int WIDTH = 128,
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opcode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [4:0]       cmd_shift,
`ifdef ALU_ISSUE_TAG_EN
    input  logic [3:0]       cmd_tag,
    output logic [3:0]       rsp_tag,
`endif
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [4:0]       alu_shift,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_zero,
    input  logic             alu_ovf,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_ovf,
    output logic [3:0]       rsp_opcode,
    output logic             busy
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [4:0]       sh;
`ifdef ALU_ISSUE_TAG_EN
        logic [3:0]       tag;
`endif
    } cmd_t;

    typedef struct packed {
        logic [3:0] op;
`ifdef ALU_ISSUE_TAG_EN
        logic [3:0] tag;
`endif
    } trk_t;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             carry;
        logic             zero;
        logic             ovf;
        logic [3:0]       op;
`ifdef ALU_ISSUE_TAG_EN
        logic [3:0]       tag;
`endif
    } rsp_t;

    cmd_t          cmd_mem [DEPTH];
    rsp_t          rsp_mem [DEPTH];
    trk_t          trk     [LAT];
    logic [AW:0]   cwp, crp, rwp, rrp;
    logic [AW:0]   outstanding;
    logic [LAT-1:0] vld;
    logic          rdy_q;
    cmd_t          cmd_in, head, last_q, alu_cmd;
    trk_t          trk_in;
    rsp_t          rsp_in, rsp_hold, rsp_out;
    logic          cmd_empty, cmd_full, cmd_push;
    logic          rsp_empty, rsp_full, rsp_wr, rsp_pop;
    logic          issue;

    assign cmd_empty = (cwp == crp);
    assign cmd_full  = (cwp[AW] != crp[AW]) && (cwp[AW-1:0] == crp[AW-1:0]);
    assign rsp_empty = (rwp == rrp);
    assign rsp_full  = (rwp[AW] != rrp[AW]) && (rwp[AW-1:0] == rrp[AW-1:0]);

    assign cmd_ready = rdy_q && !cmd_full;
    assign cmd_push  = cmd_valid && cmd_ready;
    assign head      = cmd_mem[crp[AW-1:0]];
    assign issue     = !cmd_empty && (outstanding < (AW+1)'(DEPTH));
    assign alu_cmd   = issue ? head : last_q;
    assign rsp_wr    = vld[LAT-1];
    assign rsp_valid = !rsp_empty;
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign rsp_out   = rsp_empty ? rsp_hold : rsp_mem[rrp[AW-1:0]];
    assign busy      = !cmd_empty || (|vld) || (outstanding != '0);

    assign alu_opcode = alu_cmd.op;
    assign alu_in1    = alu_cmd.a;
    assign alu_in2    = alu_cmd.b;
    assign alu_shift  = alu_cmd.sh;
    assign rsp_result = rsp_out.res;
    assign rsp_carry  = rsp_out.carry;
    assign rsp_zero   = rsp_out.zero;
    assign rsp_ovf    = rsp_out.ovf;
    assign rsp_opcode = rsp_out.op;
`ifdef ALU_ISSUE_TAG_EN
    assign rsp_tag    = rsp_out.tag;
`endif

    // Pack incoming command, tracking sideband and captured response.
    always_comb begin
        cmd_in       = '0;
        cmd_in.op    = cmd_opcode;
        cmd_in.a     = cmd_a;
        cmd_in.b     = cmd_b;
        cmd_in.sh    = cmd_shift;
        trk_in       = '0;
        trk_in.op    = alu_cmd.op;
        rsp_in       = '0;
        rsp_in.res   = alu_result;
        rsp_in.carry = alu_carry;
        rsp_in.zero  = alu_zero;
        rsp_in.ovf   = alu_ovf;
        rsp_in.op    = trk[LAT-1].op;
`ifdef ALU_ISSUE_TAG_EN
        cmd_in.tag   = cmd_tag;
        trk_in.tag   = alu_cmd.tag;
        rsp_in.tag   = trk[LAT-1].tag;
`endif
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (cmd_push) cmd_mem[cwp[AW-1:0]] <= cmd_in;
        if (rsp_wr)   rsp_mem[rwp[AW-1:0]] <= rsp_in;
    end

    // Pointers, credit counter, ready enable and held ALU/response values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cwp         <= '0;
            crp         <= '0;
            rwp         <= '0;
            rrp         <= '0;
            outstanding <= '0;
            rdy_q       <= 1'b0;
            last_q      <= '0;
            rsp_hold    <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (cmd_push) cwp <= cwp + (AW+1)'(1);
            if (issue) begin
                crp    <= crp + (AW+1)'(1);
                last_q <= head;
            end
            if (rsp_wr) rwp <= rwp + (AW+1)'(1);
            if (rsp_pop) begin
                rrp      <= rrp + (AW+1)'(1);
                rsp_hold <= rsp_out;
            end
            unique case ({issue, rsp_pop})
                2'b10:   outstanding <= outstanding + (AW+1)'(1);
                2'b01:   outstanding <= outstanding - (AW+1)'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Follow each issued command through the ALU latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < LAT; i++) trk[i] <= '0;
        end else begin
            vld[0] <= issue;
            trk[0] <= trk_in;
            for (int i = 1; i < LAT; i++) begin
                vld[i] <= vld[i-1];
                trk[i] <= trk[i-1];
            end
        end
    end

    a_no_rsp_overflow: assert property (
        @(posedge clk) disable iff (rst) !(rsp_wr && rsp_full)
    );

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Command sequencer wrapped around the pipelined ALU datapath. It accepts ALU commands over a valid/ready handshake and buffers them in a command FIFO. It issues at most one command per cycle to the ALU's raw operand ports, tracks each command through the ALU's fixed latency, and captures the ALU result and flags into a response FIFO with valid/ready backpressure. A credit counter guarantees that no issued result is ever dropped.

## Interface
- WIDTH, 128, operand/result width; matches ALU
- LAT, 2, ALU latency in clock edges from operand sample to result register
- DEPTH, 4, entries in both the command FIFO and the response FIFO; power of 2, ≥2
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command FIFO not full
- cmd_opcode  in  4  ALU opcode
- cmd_a, cmd_b  in  WIDTH  operands
- cmd_shift  in  5  rotate amount
- alu_opcode  out  4  to ALU opcode
- alu_in1, alu_in2  out  WIDTH  to ALU operands
- alu_shift  out  5  to ALU shiftValue
- alu_result  in  WIDTH  from ALU result
- alu_carry, alu_zero, alu_ovf  in  1  from ALU flags
- rsp_valid  out  1  response FIFO not empty
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  WIDTH  captured result
- rsp_carry, rsp_zero, rsp_ovf  out  1  captured flags
- rsp_opcode  out  4  opcode echoed with the result
- busy  out  1  high when any command is queued, in flight, or unread

## Operation
- Accept: cmd_valid && cmd_ready writes {opcode, a, b, shift} to the command FIFO tail.
- Credit: `outstanding` counts commands issued but not yet popped from the response FIFO (range 0..DEPTH). It increments on issue and decrements on rsp_valid && rsp_ready. When both happen in one cycle, it is unchanged.
- Issue: `issue` = command FIFO non-empty && outstanding < DEPTH.
  - alu_* is driven combinationally from the FIFO head.
  - The head pops at the edge ending the issue cycle.
  - When not issuing, alu_* holds the last issued values.
- Tracking: valid shift register vld[LAT-1:0]. vld[0] <= issue, and vld[i] <= vld[i-1]. When vld[LAT-1] is high, the current alu_result/flags belong to the oldest in-flight command. They are written into the response FIFO at the next edge, together with the opcode carried alongside in a parallel opcode shift register.
- Because of the credit check, the response FIFO write never finds the FIFO full. Hitting full on a write is an assertion failure.
- Ordering: strictly in order. Opcodes are passed through unvalidated. Results for opcodes that leave the ALU result unchanged are captured as-is.
- busy = cmd FIFO non-empty || |vld || outstanding != 0.

## Timing
- Reset values:
  - cmd_ready 0 while rst is high, then 1 from the first edge after release.
  - rsp_valid 0, busy 0.
  - alu_* all 0.
  - rsp_* data 0.
  - FIFO pointers, outstanding, and vld are all 0.
- Reset mid-operation discards all queued, in-flight and unread commands. No response is produced for them.
- Minimum latency: a command accepted at edge k into an idle block issues in cycle k→k+1. The ALU samples it at k+1, its result is valid after k+LAT, it is captured at k+LAT+1, and rsp_valid is high from edge k+LAT+1.
- Throughput: 1 command per cycle sustained while rsp_ready=1.
- Full: cmd_ready=0 when the command FIFO holds DEPTH entries. A push and a pop in the same cycle while full is not allowed, because ready is already low.
- Empty: rsp_valid=0, and rsp_* holds its last value.
- Backpressure: with rsp_ready=0, issue stops once outstanding=DEPTH. Commands then accumulate until cmd_ready drops.
- Pointers wrap modulo DEPTH. An extra wrap bit distinguishes full from empty.

## Configuration
- ALU_ISSUE_TAG_EN defined:
  - Adds cmd_tag (in, 4) and rsp_tag (out, 4).
  - The tag travels with its command through the command FIFO, the tracking shift register and the response FIFO.
  - rsp_tag resets to 0.
- Undefined: these ports and their storage are absent, and all other behaviour is identical.

## Test plan
- Single ADD:
  - Stimulus: a=5, b=7, LAT=2, rsp_ready=1, accept at edge k.
  - Required: rsp_valid from edge k+3, rsp_result=12, rsp_opcode=0, rsp_carry=0, busy low after the pop.
- Burst and order:
  - Stimulus: 8 back-to-back commands with ADD a=i, b=1, rsp_ready=1.
  - Required: 8 responses in order with results 1..8, at one per cycle with no gaps.
- Backpressure:
  - Stimulus: rsp_ready=0, 10 commands offered.
  - Required: exactly 4 issued (outstanding=4), 4 queued, cmd_ready=0. After rsp_ready is raised, all 8 drain in order and none are lost.
- Wrap and carry:
  - Stimulus: ADD with a=2^128−1, b=1.
  - Required: rsp_result=0, rsp_carry=1. This is repeated 3×DEPTH times so the pointers wrap.
- Reset mid-flight:
  - Stimulus: assert rst with 2 commands queued and 2 in flight.
  - Required: after release, rsp_valid=0, busy=0, and no stale response ever appears.
- Tag (macro on):
  - Stimulus: tags 3, 9, 15 paired with DIV 100/7, 0/0 and OR.
  - Required: rsp_tag 3, 9, 15 in order, with results 14 and 0 for the two DIVs.
